con_ff_unit: RTL

Parametrised conditional-branch unit for the datapath control path. It captures the branch-condition field of the instruction register and evaluates it against the value on the bus when the control unit strobes `con_in`. It holds the registered CON flag for the control unit's branch step. It also keeps a sequencing state, a sticky misuse flag and a saturating taken-branch counter for performance checks.

---
 rtl/con_ff_unit.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/con_ff_unit.sv
`default_nettype none
// ============================================================================
// Module   : con_ff_unit
// Purpose  : Conditional-branch (CON) flag unit. Captures the 3-bit branch
//            condition field from the instruction word, evaluates it against
//            the bus value when strobed, and holds the registered CON flag.
//            Also tracks a sequencing state, a sticky misuse flag and a
//            saturating taken-branch counter.
// Ports    : clock       - rising-edge clock
//            clear       - synchronous active-high reset
//            ir_in       - instruction word (condition field at CFIELD_LSB)
//            ir_load     - capture the condition field this cycle
//            bus_in      - value under test (Ra contents)
//            con_in      - evaluate the condition and load CON
//            count_clr   - zero the taken counter
//            con_out     - registered CON flag
//            con_valid   - con_out holds a result for the current instruction
//            con_err     - sticky: con_in seen with no condition armed
//            taken_count - saturating count of true evaluations
// Revision : 1.0 - initial release
// ============================================================================
module con_ff_unit #(
  parameter int DATA_W     = 32,
  parameter int CFIELD_LSB = 19,
  parameter int CNT_W      = 16
) (
  input  logic              clock,
  input  logic              clear,
  input  logic [DATA_W-1:0] ir_in,
  input  logic              ir_load,
  input  logic [DATA_W-1:0] bus_in,
  input  logic              con_in,
  input  logic              count_clr,
  output logic              con_out,
  output logic              con_valid,
  output logic              con_err,
  output logic [CNT_W-1:0]  taken_count
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_ARMED    = 2'd1,
    S_RESOLVED = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

  state_t           r_state, w_state_nxt;
  logic [2:0]       r_cond, w_cond_nxt;
  logic             r_con, w_con_nxt;
  logic             r_valid, w_valid_nxt;
  logic             r_err, w_err_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;

  logic [2:0] w_ir_cond;
  logic [2:0] w_eval_cond;
  logic       w_zero;
  logic       w_neg;
  logic       w_result;
  logic       w_do_eval;

  assign w_ir_cond = ir_in[CFIELD_LSB+2:CFIELD_LSB];

  // A simultaneous ir_load uses the incoming field, not the stale held one.
  assign w_eval_cond = ir_load ? w_ir_cond : r_cond;

  assign w_zero = ~|bus_in;
  assign w_neg  = bus_in[DATA_W-1];

  always_comb begin
    w_result = 1'b0;
    case (w_eval_cond)
      3'b000: w_result = 1'b0;
      3'b001: w_result = 1'b1;
      3'b010: w_result = w_zero;
      3'b011: w_result = ~w_zero;
      3'b100: w_result = ~w_neg;
      3'b101: w_result = w_neg;
      3'b110: w_result = ~w_neg & ~w_zero;
      3'b111: w_result = w_neg | w_zero;
      default: w_result = 1'b0;
    endcase
  end

  // Evaluation needs an armed condition, or one arriving this very cycle.
  assign w_do_eval = con_in && (ir_load || (r_state != S_IDLE));

  always_comb begin
    w_state_nxt = r_state;
    w_cond_nxt  = r_cond;
    w_con_nxt   = r_con;
    w_valid_nxt = r_valid;
    w_err_nxt   = r_err;
    w_cnt_nxt   = r_cnt;

    if (ir_load) begin
      w_cond_nxt  = w_ir_cond;
      w_con_nxt   = 1'b0;
      w_valid_nxt = 1'b0;
      w_state_nxt = S_ARMED;
    end

    if (w_do_eval) begin
      w_con_nxt   = w_result;
      w_valid_nxt = 1'b1;
      w_state_nxt = S_RESOLVED;
    end else if (con_in) begin
      w_err_nxt = 1'b1;
    end

    if (count_clr) begin
      w_cnt_nxt = '0;
    end else if (w_do_eval && w_result && (r_cnt != c_CNT_MAX)) begin
      w_cnt_nxt = r_cnt + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      r_state <= S_IDLE;
      r_cond  <= 3'b000;
      r_con   <= 1'b0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cond  <= w_cond_nxt;
      r_con   <= w_con_nxt;
      r_valid <= w_valid_nxt;
      r_err   <= w_err_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  assign con_out     = r_con;
  assign con_valid   = r_valid;
  assign con_err     = r_err;
  assign taken_count = r_cnt;

endmodule
`default_nettype wire
